// File: rtl/kernel_readout.sv
// Captures one ADC sample per sample-and-hold strobe into a NUM_PXL buffer, then streams the kernel out.
// Latency: strobe to ARM 1 cycle; first output word the cycle after the final capture; drain 1 word/cycle.
// Backpressure: out_data_o/out_idx_o hold while out_valid_o & ~out_ready_i; strobes during ARM/DRAIN are dropped and flagged.
module kernel_readout #(
    parameter int DATA_W  = 10,
    parameter int NUM_PXL = 9,
    parameter int ADC_TO  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              sh_i,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              adc_valid_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [3:0]        out_idx_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {COLLECT, ARM, DRAIN} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_PXL - 1);
    localparam logic [7:0] TO_LAST  = 8'(ADC_TO - 1);

    state_t            state, next_state;
    logic              sh_q;
    logic              sh_rise;
    logic [3:0]        wr_ptr;
    logic [3:0]        rd_ptr;
    logic [7:0]        to_cnt;
    logic [DATA_W-1:0] kbuf [NUM_PXL];

    logic              wr_en;
    logic [DATA_W-1:0] wr_val;
    logic              to_inc;
    logic              to_clr;
    logic              set_to;
    logic              set_ovr;
    logic              rd_adv;
    logic              kernel_full;

    assign sh_rise = sh_i & ~sh_q;

    always_comb begin
        next_state  = state;
        wr_en       = 1'b0;
        wr_val      = '0;
        to_inc      = 1'b0;
        to_clr      = 1'b0;
        set_to      = 1'b0;
        set_ovr     = 1'b0;
        rd_adv      = 1'b0;
        kernel_full = 1'b0;
        case (state)
            COLLECT: begin
                if (sh_rise) begin
                    next_state = ARM;
                    to_clr     = 1'b1;
                end
            end
            ARM: begin
                set_ovr = sh_rise;
                // A real conversion takes priority over a timeout landing in the same cycle.
                if (adc_valid_i) begin
                    wr_en  = 1'b1;
                    wr_val = adc_data_i;
                end else if (to_cnt == TO_LAST) begin
                    wr_en  = 1'b1;
                    set_to = 1'b1;
                end else begin
                    to_inc = 1'b1;
                end
                if (wr_en) begin
                    kernel_full = (wr_ptr == LAST_IDX);
                    next_state  = kernel_full ? DRAIN : COLLECT;
                end
            end
            DRAIN: begin
                set_ovr = sh_rise;
                if (out_ready_i) begin
                    if (rd_ptr == LAST_IDX) next_state = COLLECT;
                    else                    rd_adv     = 1'b1;
                end
            end
            default: next_state = COLLECT;
        endcase
        if (clear_i) next_state = COLLECT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= COLLECT;
        else       state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            to_cnt    <= '0;
            overrun_o <= 1'b0;
            timeout_o <= 1'b0;
            for (int i = 0; i < NUM_PXL; i++) kbuf[i] <= '0;
        end else begin
            sh_q <= sh_i;
            if (clear_i) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                to_cnt    <= '0;
                overrun_o <= 1'b0;
                timeout_o <= 1'b0;
            end else begin
                if (to_clr)      to_cnt <= '0;
                else if (to_inc) to_cnt <= to_cnt + 8'd1;
                if (wr_en) begin
                    kbuf[wr_ptr] <= wr_val;
                    if (kernel_full) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end else begin
                        wr_ptr <= wr_ptr + 4'd1;
                    end
                end
                if (rd_adv)  rd_ptr    <= rd_ptr + 4'd1;
                if (set_ovr) overrun_o <= 1'b1;
                if (set_to)  timeout_o <= 1'b1;
            end
        end
    end

    assign out_valid_o = (state == DRAIN);
    assign out_data_o  = out_valid_o ? kbuf[rd_ptr] : '0;
    assign out_idx_o   = out_valid_o ? rd_ptr : 4'd0;
    assign out_last_o  = out_valid_o && (rd_ptr == LAST_IDX);
    assign busy_o      = (state != COLLECT);

endmodule

// File: tb/tb_kernel_readout.sv
// Directed bench for kernel_readout: capture, drain, timeout, overrun and abort paths.
module tb_kernel_readout;

    localparam int DATA_W  = 10;
    localparam int NUM_PXL = 9;
    localparam int ADC_TO  = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear_i;
    logic              sh_i;
    logic [DATA_W-1:0] adc_data_i;
    logic              adc_valid_i;
    logic [DATA_W-1:0] out_data_o;
    logic [3:0]        out_idx_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              out_last_o;
    logic              busy_o;
    logic              overrun_o;
    logic              timeout_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [DATA_W-1:0] exp_dat [NUM_PXL];

    kernel_readout #(.DATA_W(DATA_W), .NUM_PXL(NUM_PXL), .ADC_TO(ADC_TO)) dut (
        .clk(clk), .reset(reset), .clear_i(clear_i), .sh_i(sh_i),
        .adc_data_i(adc_data_i), .adc_valid_i(adc_valid_i),
        .out_data_o(out_data_o), .out_idx_o(out_idx_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_last_o(out_last_o), .busy_o(busy_o),
        .overrun_o(overrun_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        sh_i = 1'b1;
        step();
        sh_i = 1'b0;
    endtask

    task automatic capture(input logic [DATA_W-1:0] d);
        strobe();
        step();
        step();
        adc_valid_i = 1'b1;
        adc_data_i  = d;
        step();
        adc_valid_i = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating
    task automatic drain(input int mode, input int n_hs, output int cycles);
        int hs;
        logic stall;
        logic [DATA_W-1:0] pd;
        logic [3:0] pi;
        hs = 0; cycles = 0; stall = 1'b0; pd = '0; pi = '0;
        while (hs < n_hs && cycles < 200) begin
            out_ready_i = (mode == 0) ? 1'b1 : ((cycles % 3) == 0);
            if (stall) begin
                chk("hold_dat", 32'(out_data_o), 32'(pd));
                chk("hold_idx", 32'(out_idx_o), 32'(pi));
            end
            if (out_valid_o && out_ready_i) begin
                chk("word_idx", 32'(out_idx_o), 32'(hs));
                chk("word_dat", 32'(out_data_o), 32'(exp_dat[hs]));
                chk("word_last", 32'(out_last_o), 32'(hs == NUM_PXL - 1));
                hs++;
            end
            stall = out_valid_o && !out_ready_i;
            pd = out_data_o;
            pi = out_idx_o;
            cycles++;
            step();
        end
        out_ready_i = 1'b0;
        chk("handshakes", 32'(hs), 32'(n_hs));
    endtask

    initial begin
        int cyc;
        reset = 1'b1; clear_i = 1'b0; sh_i = 1'b0; adc_data_i = '0;
        adc_valid_i = 1'b0; out_ready_i = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_flags", 32'({overrun_o, timeout_o, out_last_o}), 0);
        chk("rst_dat_idx", 32'({out_data_o, out_idx_o}), 0);
        reset = 1'b0;
        step();

        // Nominal kernel
        strobe();
        chk("strobe_to_arm", 32'(busy_o), 1);
        step(); step();
        adc_valid_i = 1'b1; adc_data_i = 10'h100;
        step();
        adc_valid_i = 1'b0;
        chk("capture_leaves_arm", 32'(busy_o), 0);
        for (int i = 1; i < NUM_PXL; i++) capture(10'(10'h100 + i));
        chk("drain_start", 32'(out_valid_o), 1);
        for (int i = 0; i < NUM_PXL; i++) exp_dat[i] = 10'(10'h100 + i);
        drain(0, NUM_PXL, cyc);
        chk("drain_cycles", 32'(cyc), NUM_PXL);
        chk("post_valid", 32'(out_valid_o), 0);
        chk("post_busy", 32'(busy_o), 0);
        chk("nom_flags", 32'({overrun_o, timeout_o}), 0);

        // Backpressure, same samples (held-high strobe must count once)
        sh_i = 1'b1;
        step();
        step(); step(); step();
        adc_valid_i = 1'b1; adc_data_i = 10'h100;
        step();
        adc_valid_i = 1'b0;
        step();
        chk("held_strobe_once", 32'({busy_o, overrun_o}), 0);
        sh_i = 1'b0;
        step();
        for (int i = 1; i < NUM_PXL; i++) capture(10'(10'h100 + i));
        drain(1, NUM_PXL, cyc);
        chk("bp_busy", 32'(busy_o), 0);

        // ADC timeout, then a late adc_valid in COLLECT
        strobe();
        for (int i = 0; i < ADC_TO - 1; i++) step();
        chk("to_pre_busy", 32'(busy_o), 1);
        chk("to_pre_flag", 32'(timeout_o), 0);
        step();
        chk("to_busy", 32'(busy_o), 0);
        chk("to_flag", 32'(timeout_o), 1);
        adc_valid_i = 1'b1; adc_data_i = 10'h3FF;
        step();
        adc_valid_i = 1'b0;
        chk("late_valid_ignored", 32'(busy_o), 0);
        for (int i = 1; i < NUM_PXL; i++) capture(10'(10'h200 + i));
        exp_dat[0] = '0;
        for (int i = 1; i < NUM_PXL; i++) exp_dat[i] = 10'(10'h200 + i);
        drain(0, NUM_PXL, cyc);

        // adc_valid exactly in the timeout cycle
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clear_flags", 32'({overrun_o, timeout_o}), 0);
        strobe();
        for (int i = 0; i < ADC_TO - 1; i++) step();
        adc_valid_i = 1'b1; adc_data_i = 10'h2AA;
        step();
        adc_valid_i = 1'b0;
        chk("sim_timeout_flag", 32'(timeout_o), 0);
        chk("sim_busy", 32'(busy_o), 0);
        for (int i = 1; i < NUM_PXL; i++) capture(10'(10'h280 + i));
        exp_dat[0] = 10'h2AA;
        for (int i = 1; i < NUM_PXL; i++) exp_dat[i] = 10'(10'h280 + i);
        drain(0, NUM_PXL, cyc);

        // Overrun in ARM, then in DRAIN with ready low
        strobe();
        step();
        sh_i = 1'b1;
        step();
        sh_i = 1'b0;
        chk("ovr_arm", 32'(overrun_o), 1);
        adc_valid_i = 1'b1; adc_data_i = 10'h180;
        step();
        adc_valid_i = 1'b0;
        for (int i = 1; i < NUM_PXL; i++) capture(10'(10'h180 + i));
        strobe();
        step();
        chk("ovr_drain_idx", 32'(out_idx_o), 0);
        chk("ovr_drain_valid", 32'(out_valid_o), 1);
        for (int i = 0; i < NUM_PXL; i++) exp_dat[i] = 10'(10'h180 + i);
        drain(0, NUM_PXL, cyc);
        chk("ovr_sticky", 32'(overrun_o), 1);
        for (int i = 0; i < NUM_PXL - 1; i++) capture(10'(10'h300 + i));
        chk("wr_ptr_unchanged", 32'(busy_o), 0);
        capture(10'h308);
        chk("kernel_full_drain", 32'(out_valid_o), 1);

        // clear_i after 4 handshakes
        for (int i = 0; i < NUM_PXL; i++) exp_dat[i] = 10'(10'h300 + i);
        drain(0, 4, cyc);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clr_valid", 32'(out_valid_o), 0);
        chk("clr_busy", 32'(busy_o), 0);
        chk("clr_flags", 32'({overrun_o, timeout_o}), 0);
        for (int i = 0; i < NUM_PXL; i++) capture(10'(10'h380 + i));
        for (int i = 0; i < NUM_PXL; i++) exp_dat[i] = 10'(10'h380 + i);
        drain(0, NUM_PXL, cyc);

        // Async reset mid-ARM
        strobe();
        step();
        sh_i = 1'b1;
        step();
        sh_i = 1'b0;
        chk("pre_rst_state", 32'({busy_o, overrun_o}), 32'b11);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_flags", 32'({overrun_o, timeout_o, out_valid_o, out_last_o}), 0);
        chk("arst_dat_idx", 32'({out_data_o, out_idx_o}), 0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_idle", 32'(busy_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/kernel_readout.md
# kernel_readout

Downstream of the pixel sequencer. Captures one ADC conversion per pixel sample-and-hold strobe into a 3x3 kernel buffer. Once all NUM_PXL samples are held, streams them out over a valid/ready interface to the host-side readout logic. Flags samples that are dropped or that arrive late.

## Interface
- DATA_W, 10, ADC sample width.
- NUM_PXL, 9, samples per kernel (2..15).
- ADC_TO, 15, timeout in cycles to wait for adc_valid_i after a strobe (1..255).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- clear_i  in  1  synchronous abort: empties the buffer and clears sticky flags.
- sh_i  in  1  sample-and-hold strobe from the pixel sequencer; high ≥1 cycle per pixel, rising edge used.
- adc_data_i  in  DATA_W  ADC conversion result.
- adc_valid_i  in  1  one-cycle qualifier for adc_data_i.
- out_data_o  out  DATA_W  sample at out_idx_o.
- out_idx_o  out  4  sample index 0..NUM_PXL-1.
- out_valid_o  out  1  out_data_o/out_idx_o valid.
- out_ready_i  in  1  consumer accepts the word.
- out_last_o  out  1  high with out_valid_o on index NUM_PXL-1.
- busy_o  out  1  high in ARM or DRAIN.
- overrun_o  out  1  sticky: a strobe was dropped.
- timeout_o  out  1  sticky: an ADC wait expired.

## Operation
- **Strobe detect:** register sh_q <= sh_i; sh_rise = sh_i & ~sh_q.
- **FSM states:** COLLECT, ARM, DRAIN.
- **COLLECT:**
  - sh_rise -> ARM, and to_cnt <= 0.
  - adc_valid_i is ignored.
- **ARM:**
  - adc_valid_i -> buf[wr_ptr] <= adc_data_i.
  - Else, if to_cnt == ADC_TO-1 -> buf[wr_ptr] <= 0 and timeout_o <= 1.
  - Else to_cnt++.
  - On either write: if wr_ptr == NUM_PXL-1, then wr_ptr <= 0, rd_ptr <= 0, and go to DRAIN. Otherwise wr_ptr++ and go to COLLECT.
  - adc_valid_i wins over timeout on the same cycle.
  - sh_rise while in ARM sets overrun_o; the strobe is not queued.
- **DRAIN:**
  - out_valid_o = 1; out_data_o = buf[rd_ptr]; out_idx_o = rd_ptr.
  - On out_valid_o & out_ready_i: if rd_ptr == NUM_PXL-1, go to COLLECT; else rd_ptr++.
  - out_data_o and out_idx_o hold stable while out_valid_o & ~out_ready_i.
  - sh_rise in DRAIN sets overrun_o and the sample is dropped (wr_ptr unchanged).
- **clear_i:**
  - Overrides all other activity on the cycle it is sampled high.
  - Result: state COLLECT, wr_ptr = rd_ptr = to_cnt = 0, overrun_o = timeout_o = 0.
  - Buffer contents are not cleared.
- **Widths:** to_cnt is 8 bits. Pointers are 4 bits and never exceed NUM_PXL-1.

## Timing
- **Reset values:**
  - Outputs: out_valid_o = 0, out_last_o = 0, out_idx_o = 0, out_data_o = 0, busy_o = 0, overrun_o = 0, timeout_o = 0.
  - Internal: state COLLECT, sh_q = 0, buf all 0, pointers 0.
- **Reset mid-operation:** a reset asserted in ARM or DRAIN discards the partial kernel or the undrained words.
- **Strobe to ARM:** sh_i rises in cycle N; state = ARM in cycle N+1.
- **Strobe held high:** an sh_i held high for many cycles counts as one strobe only.
- **ADC capture:** adc_valid_i in cycle M (state ARM) writes on the edge ending cycle M. State leaves ARM in cycle M+1.
- **Timeout:** with no adc_valid_i, the write happens in the ADC_TO-th ARM cycle, counting the entry cycle as the 1st.
- **Drain start:** after the last write, out_valid_o = 1 in the next cycle.
- **Drain throughput:** with out_ready_i held high, the kernel drains in NUM_PXL consecutive cycles. out_valid_o falls in the cycle after the last handshake.
- **Strobe at drain end:** sh_rise in the same cycle as the final DRAIN handshake is an overrun (state is still DRAIN).
- **Strobe after drain:** the earliest accepted strobe is the first cycle in COLLECT.

## Test plan
- **Nominal kernel:** 9 strobes, each followed 3 cycles later by adc_valid_i with data 0x100+i; out_ready_i = 1.
  - Required: 9 consecutive words 0x100..0x108 with idx 0..8.
  - Required: out_last_o only on idx 8; busy_o low afterwards.
  - Required: overrun_o = 0 and timeout_o = 0.
- **Backpressure:** drain a full kernel with out_ready_i toggling 1,0,0,1…
  - Required: every word is held stable while not ready.
  - Required: no word is lost or repeated; exactly 9 handshakes.
- **ADC timeout:** strobe with no adc_valid_i for ADC_TO cycles, then a late adc_valid_i.
  - Required: buf[0] = 0 and timeout_o = 1.
  - Required: the late adc_valid_i is ignored in COLLECT; the next strobe writes idx 1.
- **Simultaneous valid/timeout:** adc_valid_i (data 0x2AA) arrives exactly in the timeout cycle.
  - Required: 0x2AA is stored and timeout_o stays 0.
- **Overrun:** strobe during ARM, then a strobe during DRAIN with out_ready_i = 0.
  - Required: overrun_o = 1; wr_ptr unchanged; the drained data matches the original 9 samples.
- **Abort paths:**
  - clear_i in DRAIN after 4 handshakes -> state COLLECT, out_valid_o = 0 next cycle, flags cleared; the next kernel starts at idx 0.
  - Async reset mid-ARM -> all outputs return to their reset values immediately.
